// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte channel between NUM_REQ requesters.
// Each requester has a one-byte holding register. Packets are never interleaved,
// new packets start in round-robin order, and a lock timeout releases the channel
// from a requester that stops feeding its packet.

// One requester's holding register: {last, data} plus a full flag.
module uart_tx_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_data,
  input  logic [7:0] data,
  input  logic       last,
  input  logic       clr,
  output logic       full,
  output logic [7:0] hold_data,
  output logic       hold_last
);

  // Capture only into an empty hold. clr is only raised while full, so a
  // same-cycle new_data is dropped because full is still 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (clr) begin
      full      <= 1'b0;
    end else if (new_data && !full) begin
      full      <= 1'b1;
      hold_data <= data;
      hold_last <= last;
    end
  end

endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_new_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_new_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOCKED, GUARD} state_t;

  state_t                    state, state_n;
  logic [IW-1:0]             rr, rr_n;
  logic [IW-1:0]             owner, owner_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic                      last_q, last_n;
  logic [NUM_REQ-1:0]        grant_n;
  logic                      locked_n;
  logic [7:0]                tx_data_n;
  logic                      tx_new_n;

  logic [NUM_REQ-1:0]        hold_full, hold_last, hold_clr;
  logic [NUM_REQ-1:0][7:0]   hold_data;

  logic                      found;
  logic [IW-1:0]             pick_idx;
  logic [IW-1:0]             iss_idx;
  logic                      can_iss;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
    uart_tx_hold u_hold (
      .clk       (clk),
      .rst       (rst),
      .new_data  (req_new_data[g]),
      .data      (req_data[8*g +: 8]),
      .last      (req_last[g]),
      .clr       (hold_clr[g]),
      .full      (hold_full[g]),
      .hold_data (hold_data[g]),
      .hold_last (hold_last[g])
    );
  end

  assign req_busy = hold_full;

  // Round-robin pick: first full hold strictly after the rr pointer, wrapping.
  always_comb begin
    int j;
    found    = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr) + k) % NUM_REQ;
      if (!found && hold_full[IW'(j)]) begin
        found    = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Issue source: any requester when idle, only the owner while locked.
  always_comb begin
    iss_idx = (state == LOCKED) ? owner : pick_idx;
    can_iss = !tx_busy &&
              (((state == IDLE) && found) || ((state == LOCKED) && hold_full[owner]));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n   = state;
    rr_n      = rr;
    owner_n   = owner;
    cnt_n     = cnt;
    last_n    = last_q;
    grant_n   = grant;
    locked_n  = locked;
    tx_data_n = tx_data;
    tx_new_n  = 1'b0;
    hold_clr  = '0;
    if (can_iss) begin
      hold_clr[iss_idx] = 1'b1;
      tx_data_n         = hold_data[iss_idx];
      tx_new_n          = 1'b1;
      last_n            = hold_last[iss_idx];
      owner_n           = iss_idx;
      cnt_n             = '0;
      state_n           = GUARD;
      if (hold_last[iss_idx]) begin
        // Packet ends here: release and move the pointer past this requester.
        rr_n     = iss_idx;
        grant_n  = '0;
        locked_n = 1'b0;
      end else begin
        grant_n  = NUM_REQ'(1) << iss_idx;
        locked_n = 1'b1;
      end
    end else begin
      case (state)
        // One dead cycle so uart_tx has time to raise busy.
        GUARD: state_n = last_q ? IDLE : LOCKED;
        LOCKED: begin
          // Count only while the owner leaves its hold empty; a full hold
          // stalled by tx_busy is not the owner's fault.
          if (!hold_full[owner]) begin
            if (cnt != '1) cnt_n = cnt + 1'b1;
            if ((LOCK_TIMEOUT != 0) && (cnt_n == TO)) begin
              state_n  = IDLE;
              grant_n  = '0;
              locked_n = 1'b0;
              rr_n     = owner;
              cnt_n    = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= IW'(NUM_REQ - 1);
      owner       <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      grant       <= '0;
      locked      <= 1'b0;
      tx_data     <= '0;
      tx_new_data <= 1'b0;
    end else begin
      state       <= state_n;
      rr          <= rr_n;
      owner       <= owner_n;
      cnt         <= cnt_n;
      last_q      <= last_n;
      grant       <= grant_n;
      locked      <= locked_n;
      tx_data     <= tx_data_n;
      tx_new_data <= tx_new_n;
    end
  end

endmodule
